spi_link_scheduler: RTL
=======================

# spi_link_scheduler

Master-side sequencer and arbiter for the serial register link to the SPI slave memory agent. It accepts single-word read/write requests from up to NUM_REQ requesters (AHB bridge, debug port, …) and grants them round-robin. Each granted request becomes one 41-bit packet `{wr, addr[7:0], data[31:0]}`, shifted MSB-first on `mosi` under `cs`/`spi_clk`. For reads it also collects the 32-bit reply from `miso`, then returns a completion to the owning requester.

## Interface
- NUM_REQ, 2: number of requesters (1..8)
- SCLK  in  1  system clock; all logic on the rising edge
- SRESET  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_wr  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  8*NUM_REQ  word address, slice i = requester i
- req_wdata  in  32*NUM_REQ  write data, slice i = requester i
- req_ready  out  NUM_REQ  one-hot accept pulse
- rsp_valid  out  NUM_REQ  one-hot completion pulse
- rsp_rdata  out  32  read data, qualified by rsp_valid; 0 for writes
- busy  out  1  high from accept until the end of the inter-packet gap
- spi_clk  out  1  serial clock to slave
- cs  out  1  chip select, active low
- mosi  out  1  serial data to slave
- miso  in  1  serial data from slave

## Operation
- States:
  - IDLE → SETUP → SHIFT_OUT → (write) DONE / (read) TURN → SHIFT_IN → DONE
  - DONE → GAP → IDLE
- IDLE:
  - If any req_valid is set, grant the first requester at or after `rr_ptr`, searching upward and wrapping.
  - Pulse req_ready[g] for one cycle and latch wr, addr and wdata from slice g.
  - Set `rr_ptr` = (g+1) mod NUM_REQ.
  - Requests not granted wait. A requester holds req_valid and its fields stable until req_ready.
- Packet bit 40 = wr, 39:32 = addr, 31:0 = wdata. For reads, wdata is sent as 0.
- SETUP: cs low, spi_clk low, for SETUP_CYC = 2 cycles.
- SHIFT_OUT: 41 bit-slots, MSB first. Each slot is one spi_clk-low cycle then one spi_clk-high cycle. mosi changes only at the start of the low cycle.
- TURN (read only): spi_clk held high for TURN_CYC = 3 cycles. mosi = 0. The slave prepares its reply.
- SHIFT_IN: 32 slots, each one low cycle then one high cycle. The slave drives a bit during the low cycle. It is sampled into the shift register on the high cycle, MSB first.
- DONE: cs high, spi_clk low, mosi 0. Pulse rsp_valid[g] with rsp_rdata for one cycle.
- GAP: cs high for GAP_CYC = 2 cycles total, DONE included. Then IDLE.
- Only one transaction is outstanding at a time. New requests are never accepted while busy.
- A requester dropping req_valid after its accept has no effect. The transaction completes.
- SRESET in any state: the transaction is abandoned, no rsp_valid is issued, rr_ptr = 0, state = IDLE.

## Timing
- Reset values: cs = 1, spi_clk = 0, mosi = 0, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, busy = 0.
- All outputs are registered.
- Accept at cycle A (req_ready high at A). cs falls at A+1. SETUP covers A+1..A+2. SHIFT_OUT covers A+3..A+84.
- Write: rsp_valid at A+85. Earliest next req_ready is A+87.
- Read: TURN covers A+85..A+87, SHIFT_IN covers A+88..A+151, rsp_valid at A+152. Earliest next req_ready is A+154.
- busy is high from A+1 through the last GAP cycle.
- spi_clk high and low phases are exactly one SCLK cycle each, except during TURN. The slave consumes exactly one bit per high cycle.

## Structure
- Package `spi_link_pkg`:
  - PKT_W = 41, ADDR_W = 8, DATA_W = 32
  - field index constants WR_BIT = 40, ADDR_MSB = 39, ADDR_LSB = 32
  - SETUP_CYC, TURN_CYC, GAP_CYC
  - state enum `link_state_t`
- Sub-module `rr_arbiter`: combinational one-hot grant from req_valid and rr_ptr. The pointer register lives in the parent.
- Top FSM, bit counter (6 bit), phase toggle, and 41-bit out / 32-bit in shift registers live in spi_link_scheduler.

## Test plan
- Reset, then idle 10 cycles → cs = 1, spi_clk = 0, mosi = 0, busy = 0 throughout.
- Req0 writes addr 0x12, data 0xDEADBEEF → mosi carries 1, 0x12, 0xDEADBEEF MSB-first on the 41 high cycles. rsp_valid[0] at A+85 with rdata 0.
- Req1 reads addr 0x12 against the slave model after the previous write → rsp_valid[1] at A+152, rsp_rdata = 0xDEADBEEF. Exactly 32 spi_clk high cycles in SHIFT_IN.
- Both requesters held valid for 4 transactions from reset → grant order 0, 1, 0, 1. Each req_ready precedes its own rsp_valid. No overlap of cs-low windows.
- SRESET asserted at A+40 of a write → the next cycle shows cs = 1, spi_clk = 0, busy = 0, no rsp_valid. A fresh request completes normally.
- Back-to-back writes from req0 → cs is high for at least 2 cycles between packets, and the second req_ready is at A+87.

Source files
------------

// File: rtl/spi_link_scheduler_pkg.sv
// Shared constants and state encoding for the serial register link sequencer.
package spi_link_pkg;

    localparam int PKT_W     = 41;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 32;
    localparam int WR_BIT    = 40;
    localparam int ADDR_MSB  = 39;
    localparam int ADDR_LSB  = 32;
    localparam int SETUP_CYC = 2;
    localparam int TURN_CYC  = 3;
    // GAP_CYC counts the DONE cycle as part of the chip-select-high gap.
    localparam int GAP_CYC   = 2;
    localparam int CNT_W     = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_OUT,
        ST_TURN,
        ST_SHIFT_IN,
        ST_DONE,
        ST_GAP
    } link_state_t;

endpackage

// File: rtl/spi_link_scheduler_if.sv
// Requester handshake and serial pin bundle between the link sequencer and its peers.
interface spi_link_scheduler_if #(parameter int NUM_REQ = 2);
    import spi_link_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_wr;
    logic [ADDR_W*NUM_REQ-1:0] req_addr;
    logic [DATA_W*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      busy;
    logic                      spi_clk;
    logic                      cs;
    logic                      mosi;
    logic                      miso;

    modport master (
        input  req_valid, req_wr, req_addr, req_wdata, miso,
        output req_ready, rsp_valid, rsp_rdata, busy, spi_clk, cs, mosi
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wdata, miso,
        input  req_ready, rsp_valid, rsp_rdata, busy, spi_clk, cs, mosi
    );

endinterface

// File: rtl/spi_link_scheduler_rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    always_comb begin
        int j;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        j       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!gnt_any && req[j]) begin
                gnt_any = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/spi_link_scheduler.sv
// Round-robin requester arbitration and 41-bit packet sequencing onto the serial link.
//   state     | meaning
//   ST_IDLE   | waiting for a request; grants and latches one
//   ST_SETUP  | cs low, clock parked low before the first bit
//   ST_SHIFT_OUT | 41 low/high slots carrying {wr, addr, wdata}
//   ST_TURN   | read only: clock held high while slave prepares reply
//   ST_SHIFT_IN  | 32 low/high slots sampling miso
//   ST_DONE   | cs high, completion pulse to owner
//   ST_GAP    | remainder of the cs-high gap before next grant
module spi_link_scheduler
    import spi_link_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input logic                SCLK,
    input logic                SRESET,
    spi_link_scheduler_if.master bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    link_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               phase_q, phase_d;
    logic [PKT_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic               wr_q, wr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               samp_q, samp_d;
    logic               cs_q, cs_d;
    logic               spi_clk_q, spi_clk_d;
    logic               mosi_q, mosi_d;
    logic               busy_q, busy_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Pin values are decoded from the current state and registered, so every
    // output trails the state register by one cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        tx_d        = tx_q;
        wr_d        = wr_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        rx_d        = samp_q ? {rx_q[DATA_W-2:0], bus.miso} : rx_q;
        samp_d      = 1'b0;
        cs_d        = 1'b1;
        spi_clk_d   = 1'b0;
        mosi_d      = 1'b0;
        busy_d      = (state_q != ST_IDLE);
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    req_ready_d = gnt;
                    wr_d        = bus.req_wr[gnt_idx];
                    tx_d        = {bus.req_wr[gnt_idx],
                                   bus.req_addr[gnt_idx*ADDR_W +: ADDR_W],
                                   bus.req_wr[gnt_idx] ? bus.req_wdata[gnt_idx*DATA_W +: DATA_W]
                                                       : {DATA_W{1'b0}}};
                    owner_d     = gnt_idx;
                    rr_ptr_d    = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
                    cnt_d       = CNT_W'(SETUP_CYC - 1);
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cs_d = 1'b0;
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(PKT_W - 1);
                    phase_d = 1'b0;
                    state_d = ST_SHIFT_OUT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SHIFT_OUT: begin
                cs_d      = 1'b0;
                spi_clk_d = phase_q;
                mosi_d    = tx_q[PKT_W-1];
                phase_d   = ~phase_q;
                if (phase_q) begin
                    tx_d = {tx_q[PKT_W-2:0], 1'b0};
                    if (cnt_q == '0) begin
                        if (wr_q) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d   = CNT_W'(TURN_CYC - 1);
                            state_d = ST_TURN;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_TURN: begin
                cs_d      = 1'b0;
                spi_clk_d = 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(DATA_W - 1);
                    phase_d = 1'b0;
                    state_d = ST_SHIFT_IN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SHIFT_IN: begin
                cs_d      = 1'b0;
                spi_clk_d = phase_q;
                samp_d    = phase_q;
                phase_d   = ~phase_q;
                if (phase_q) begin
                    if (cnt_q == '0) state_d = ST_DONE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                rsp_valid_d[owner_q] = 1'b1;
                rsp_rdata_d          = wr_q ? '0 : rx_d;
                cnt_d                = CNT_W'(GAP_CYC - 2);
                state_d              = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge SCLK) begin
        if (SRESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            wr_q        <= 1'b0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            samp_q      <= 1'b0;
            cs_q        <= 1'b1;
            spi_clk_q   <= 1'b0;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            wr_q        <= wr_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            samp_q      <= samp_d;
            cs_q        <= cs_d;
            spi_clk_q   <= spi_clk_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.cs        = cs_q;
    assign bus.spi_clk   = spi_clk_q;
    assign bus.mosi      = mosi_q;
    assign bus.busy      = busy_q;
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule
